// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, funct codes,
// ALU commands, and the one-cycle instruction decode used in DECODE.
package cpu_pkg;

   typedef enum logic [3:0] {
      ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_MEM_ADDR, ST_MEM_RD,
      ST_MEM_WR, ST_WB_MEM, ST_WB_ALU, ST_BRANCH, ST_JUMP, ST_TRAP
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_XOR = 3'b010,
      ALU_SLT = 3'b011
   } alu_cmd_e;

   // Instruction class captured in DECODE so later states never look at the IR.
   typedef enum logic [3:0] {
      K_NONE, K_RTYPE, K_ADDI, K_XORI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR
   } kind_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef struct packed {
      state_e   next;
      kind_e    kind;
      alu_cmd_e alu;
   } decode_t;

   function automatic decode_t decode_instr(input logic [5:0] op, input logic [5:0] fn);
      decode_t d;
      d.next = ST_TRAP;
      d.kind = K_NONE;
      d.alu  = ALU_ADD;
      case (op)
         OP_RTYPE: begin
            d.kind = K_RTYPE;
            d.next = ST_EXEC_R;
            case (fn)
               FN_ADD:  d.alu = ALU_ADD;
               FN_SUB:  d.alu = ALU_SUB;
               FN_SLT:  d.alu = ALU_SLT;
               FN_XOR:  d.alu = ALU_XOR;
               FN_JR: begin
                  d.kind = K_JR;
                  d.next = ST_JUMP;
               end
               default: begin
                  d.kind = K_NONE;
                  d.next = ST_TRAP;
               end
            endcase
         end
         OP_LW:   begin d.kind = K_LW;   d.next = ST_MEM_ADDR; end
         OP_SW:   begin d.kind = K_SW;   d.next = ST_MEM_ADDR; end
         OP_ADDI: begin d.kind = K_ADDI; d.next = ST_EXEC_I; d.alu = ALU_ADD; end
         OP_XORI: begin d.kind = K_XORI; d.next = ST_EXEC_I; d.alu = ALU_XOR; end
         OP_BEQ:  begin d.kind = K_BEQ;  d.next = ST_BRANCH; d.alu = ALU_SUB; end
         OP_BNE:  begin d.kind = K_BNE;  d.next = ST_BRANCH; d.alu = ALU_SUB; end
         OP_J:    begin d.kind = K_J;    d.next = ST_JUMP; end
         OP_JAL:  begin d.kind = K_JAL;  d.next = ST_JUMP; end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction/status inputs and datapath control strobes of the multicycle controller.
interface multicycle_control_if;
   logic [5:0] opmode;
   logic [5:0] functval;
   logic       zero;
   logic       mem_ready;

   logic       pc_write;
   logic       ir_write;
   logic       mem_read;
   logic       mem_write;
   logic       reg_write;
   logic       i_or_d;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_command;
   logic [1:0] pc_src;
   logic       trap;
   logic       busy;

   modport master (
      input  opmode, functval, zero, mem_ready,
      output pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_command, pc_src,
             trap, busy
   );

   modport slave (
      output opmode, functval, zero, mem_ready,
      input  pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_command, pc_src,
             trap, busy
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready in a memory state; flags the cycle
// on which the wait has reached MEM_TIMEOUT without mem_ready.
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_i,
   input  logic wait_i,
   input  logic mem_ready_i,
   output logic timeout_o
);

   localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

   logic [7:0] count_q, count_d;

   // NOTE: combinational next-state gets its default first so no path leaves it unassigned (no latch).
   always_comb begin
      count_d = count_q;
      if (start_i) begin
         count_d = '0;
      end else if (wait_i && !mem_ready_i) begin
         count_d = count_q + 8'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A late mem_ready on the limit cycle still completes the access.
   assign timeout_o = wait_i && !mem_ready_i && (count_q >= LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM. Define MULTICYCLE_CONTROL_COUNTERS_EN to build the
// cycle/instruction performance counters; otherwise both outputs are tied to 0.
module multicycle_control
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_control_if.master bus,
   output logic [CNT_W-1:0]     cycle_count,
   output logic [CNT_W-1:0]     instr_count
);

   state_e   state_q, state_d;
   kind_e    kind_q, kind_d;
   alu_cmd_e alu_q, alu_d;
   decode_t  dec;
   logic     timeout;
   logic     in_wait;
   logic     wait_start;

   assign in_wait    = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
   assign wait_start = (state_d != state_q) &&
                       ((state_d == ST_FETCH) || (state_d == ST_MEM_RD) || (state_d == ST_MEM_WR));

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk         (clk),
      .rst_n       (reset),
      .start_i     (wait_start),
      .wait_i      (in_wait),
      .mem_ready_i (bus.mem_ready),
      .timeout_o   (timeout)
   );

   // NOTE: only state and control registers are reset; the reset reaches them asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         kind_q  <= K_NONE;
         alu_q   <= ALU_ADD;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         alu_q   <= alu_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      kind_d           = kind_q;
      alu_d            = alu_q;
      dec              = decode_instr(bus.opmode, bus.functval);
      bus.pc_write     = 1'b0;
      bus.ir_write     = 1'b0;
      bus.mem_read     = 1'b0;
      bus.mem_write    = 1'b0;
      bus.reg_write    = 1'b0;
      bus.i_or_d       = 1'b0;
      bus.reg_dst      = 2'd0;
      bus.mem_to_reg   = 2'd0;
      bus.alu_src_a    = 1'b0;
      bus.alu_src_b    = 2'd0;
      bus.alu_command  = ALU_ADD;
      bus.pc_src       = 2'd0;
      bus.trap         = 1'b0;
      bus.busy         = (state_q != ST_FETCH);

      case (state_q)
         ST_FETCH: begin
            bus.mem_read = 1'b1;
            if (bus.mem_ready) begin
               bus.ir_write    = 1'b1;
               bus.pc_write    = 1'b1;
               bus.alu_src_b   = 2'd1;
               bus.alu_command = ALU_ADD;
               state_d         = ST_DECODE;
            end else if (timeout) begin
               state_d = ST_TRAP;
            end
         end
         ST_DECODE: begin
            bus.alu_src_b = 2'd3;
            state_d       = dec.next;
            kind_d        = dec.kind;
            alu_d         = dec.alu;
         end
         ST_EXEC_R: begin
            bus.alu_src_a   = 1'b1;
            bus.alu_command = alu_q;
            state_d         = ST_WB_ALU;
         end
         ST_EXEC_I: begin
            bus.alu_src_a   = 1'b1;
            bus.alu_src_b   = 2'd2;
            bus.alu_command = alu_q;
            state_d         = ST_WB_ALU;
         end
         ST_WB_ALU: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = (kind_q == K_RTYPE) ? 2'd1 : 2'd0;
            state_d       = ST_FETCH;
         end
         ST_MEM_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'd2;
            state_d       = (kind_q == K_LW) ? ST_MEM_RD : ST_MEM_WR;
         end
         ST_MEM_RD: begin
            bus.i_or_d   = 1'b1;
            bus.mem_read = 1'b1;
            if (bus.mem_ready)  state_d = ST_WB_MEM;
            else if (timeout)   state_d = ST_TRAP;
         end
         ST_MEM_WR: begin
            bus.i_or_d    = 1'b1;
            bus.mem_write = 1'b1;
            if (bus.mem_ready)  state_d = ST_FETCH;
            else if (timeout)   state_d = ST_TRAP;
         end
         ST_WB_MEM: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 2'd1;
            state_d        = ST_FETCH;
         end
         ST_BRANCH: begin
            bus.alu_src_a   = 1'b1;
            bus.alu_command = ALU_SUB;
            // BEQ takes the branch on zero, BNE on not-zero.
            if (bus.zero ^ (kind_q == K_BNE)) begin
               bus.pc_write = 1'b1;
               bus.pc_src   = 2'd1;
            end
            state_d = ST_FETCH;
         end
         ST_JUMP: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = (kind_q == K_JR) ? 2'd3 : 2'd2;
            if (kind_q == K_JAL) begin
               bus.reg_write  = 1'b1;
               bus.reg_dst    = 2'd2;
               bus.mem_to_reg = 2'd2;
            end
            state_d = ST_FETCH;
         end
         ST_TRAP: begin
            bus.trap = 1'b1;
         end
         default: begin
            state_d = ST_TRAP;
         end
      endcase
   end

`ifdef MULTICYCLE_CONTROL_COUNTERS_EN
   logic [CNT_W-1:0] cycle_q, instr_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         if (state_q != ST_TRAP) cycle_q <= cycle_q + CNT_W'(1);
         if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) instr_q <= instr_q + CNT_W'(1);
      end
   end

   assign cycle_count = cycle_q;
   assign instr_count = instr_q;
`else
   assign cycle_count = '0;
   assign instr_count = '0;
`endif

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum cycles waited for mem_ready per memory access before trap; range 1..255.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 opmode  input  6  opcode field of the instruction register.
REQ-006 functval  input  6  funct field of the instruction register.
REQ-007 zero  input  1  ALU zero flag from the current cycle.
REQ-008 mem_ready  input  1  unified memory completes the current read/write this cycle.
REQ-009 pc_write, ir_write, mem_read, mem_write, reg_write  output  1 each  single-cycle strobes.
REQ-010 i_or_d  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-011 reg_dst  output  2  0 = Rt, 1 = Rd, 2 = 31.
REQ-012 mem_to_reg  output  2  0 = ALU result, 1 = memory data, 2 = PC+4.
REQ-013 alu_src_a  output  1  0 = PC, 1 = Da; alu_src_b  output  2  0 = Db, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2.
REQ-014 alu_command  output  3  ALU operation code.
REQ-015 pc_src  output  2  0 = ALU result, 1 = branch target, 2 = jump addr, 3 = Da.
REQ-016 trap  output  1  held high in TRAP state; busy  output  1  high when not in FETCH.
REQ-017 cycle_count, instr_count  output  CNT_W  performance counters.

Function
REQ-018 States SHALL be FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, WB_ALU, BRANCH, JUMP, TRAP.
REQ-019 FETCH: mem_read=1, i_or_d=0; on mem_ready assert ir_write, pc_write, pc_src=0, alu_src_a=0, alu_src_b=1, alu_command=ADD; go DECODE. Otherwise stay.
REQ-020 DECODE: alu_src_a=0, alu_src_b=3, alu_command=ADD to precompute the branch target; next state by opcode in one cycle.
REQ-021 Opcode map: 0x00 -> EXEC_R (funct 0x08 JR -> JUMP); 0x23/0x2B -> MEM_ADDR; 0x08/0x0E -> EXEC_I; 0x04/0x05 -> BRANCH; 0x02/0x03 -> JUMP; all others -> TRAP.
REQ-022 R-type funct: 0x20 ADD, 0x22 SUB, 0x2A SLT, 0x26 XOR; other funct -> TRAP from DECODE.
REQ-023 EXEC_R/EXEC_I: alu_src_a=1, alu_src_b=0 (R) or 2 (I), alu_command per funct or ADD (0x08)/XOR (0x0E); next WB_ALU.
REQ-024 WB_ALU: reg_write=1, reg_dst=1 (R) or 0 (I), mem_to_reg=0; next FETCH.
REQ-025 MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD; next MEM_RD (LW) or MEM_WR (SW).
REQ-026 MEM_RD/MEM_WR: i_or_d=1, mem_read or mem_write held until mem_ready; then WB_MEM (LW) or FETCH (SW).
REQ-027 WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1; next FETCH.
REQ-028 BRANCH: alu_src_a=1, alu_src_b=0, SUB; pc_write=1, pc_src=1 iff (zero XOR opcode==0x05); next FETCH.
REQ-029 JUMP: pc_write=1, pc_src=2 (J/JAL) or 3 (JR); JAL also reg_write=1, reg_dst=2, mem_to_reg=2; next FETCH.
REQ-030 Memory wait: counter cleared on entering FETCH/MEM_RD/MEM_WR, increments each cycle mem_ready=0; reaching MEM_TIMEOUT -> TRAP next cycle; mem_ready on the same cycle as timeout wins.
REQ-031 TRAP: all strobes 0, trap=1, exits only by reset.
REQ-032 Strobes not listed for a state SHALL be 0; selects default 0.
REQ-033 Outputs SHALL be decoded from registered state only (Moore except mem_ready-qualified strobes of REQ-019/026).

Reset
REQ-034 reset low SHALL immediately force FETCH, wait counter 0, counters 0, trap 0; mid-access reset abandons the access with no strobe.
REQ-035 First fetch SHALL begin the first rising edge after reset deasserts.

Configuration
REQ-036 MULTICYCLE_CONTROL_COUNTERS_EN defined: cycle_count increments every non-TRAP cycle, instr_count increments on each return to FETCH; both wrap at 2^CNT_W.
REQ-037 Macro undefined: counter logic absent, cycle_count and instr_count tied 0.

Structure
REQ-038 Shared package cpu_pkg SHALL hold opcode, funct, ALU command (ADD=000, SUB=001, XOR=010, SLT=011) and state encodings.
REQ-039 One sub-module mem_wait_timer SHALL implement the REQ-030 counter and timeout flag.

Verification
REQ-040 ADD (op 0x00, funct 0x20), mem_ready=1 -> FETCH,DECODE,EXEC_R,WB_ALU; reg_write with reg_dst=1 in cycle 4.
REQ-041 LW with mem_ready delayed 3 cycles in MEM_RD -> mem_read held 4 cycles, then WB_MEM with mem_to_reg=1.
REQ-042 BNE with zero=0 -> pc_write=1, pc_src=1; BEQ with zero=0 -> pc_write=0.
REQ-043 JAL -> JUMP with reg_dst=2, mem_to_reg=2, pc_src=2; JR (funct 0x08) -> pc_src=3, reg_write=0.
REQ-044 mem_ready held 0 in FETCH, MEM_TIMEOUT=15 -> trap=1 after 16 cycles; opcode 0x3F -> trap after DECODE.
REQ-045 reset pulsed low during MEM_WR -> mem_write drops immediately, FETCH resumes; with COUNTERS_EN, 3 instructions -> instr_count=3.
